// File: rtl/alu_frame_sequencer_pkg.sv
// Shared types for the ALU frame sequencer: scan FSM states and status widths.
package alu_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } seq_state_e;

    localparam int unsigned FRAME_CNT_W = 8;

endpackage

// File: rtl/alu_pipe_delay.sv
// Fixed-depth shift register of {valid, addr} that tracks reads in flight through the
// buffer-read + ALU latency; the last stage drives the frame-buffer write side.
module alu_pipe_delay #(
    parameter int unsigned Depth = 2,
    parameter int unsigned AddrW = 17
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hold_i,
    input  logic             valid_i,
    input  logic [AddrW-1:0] addr_i,
    output logic             valid_o,
    output logic [AddrW-1:0] addr_o,
    output logic             pending_o
);

    logic [Depth-1:0] valid_q;
    logic [AddrW-1:0] addr_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                addr_q[i] <= '0;
            end
        end else if (!hold_i) begin
            valid_q[0] <= valid_i;
            addr_q[0]  <= addr_i;
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    // Entries still behind the output stage; the output entry itself is excluded.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < Depth - 1; i++) begin
            pending_o = pending_o | valid_q[i];
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign addr_o  = addr_q[Depth-1];

endmodule

// File: rtl/alu_frame_sequencer.sv
// Raster-scans the interior of a stored frame, issuing processing-buffer reads and the
// matching delayed frame-buffer writes; latches the kernel select for the whole frame.
module alu_frame_sequencer
    import alu_frame_sequencer_pkg::*;
#(
    parameter int unsigned IMG_W    = 320,
    parameter int unsigned IMG_H    = 240,
    parameter int unsigned AW_P     = 17,
    parameter int unsigned AW_F     = 17,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned KSEL_W   = 2
) (
    input  logic                   CLK100MHZ,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    input  logic [KSEL_W-1:0]      kernel_sel,
    output logic [KSEL_W-1:0]      kernel_sel_q,
    output logic [AW_P-1:0]        raddr_alu,
    output logic [AW_F-1:0]        waddr_alu,
    output logic                   wen_alu,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    seq_state_e       state_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [AW_P-1:0]  row_base_q;
    logic             issue_valid_q;

    logic             pipe_hold;
    logic             pipe_valid;
    logic             pipe_pending;
    logic [AW_F-1:0]  pipe_addr;
    logic [AW_F-1:0]  issue_addr;
    logic             row_end;
    logic             last_pixel;

    assign row_end    = (x_q == XW'(IMG_W - 2));
    assign last_pixel = row_end && (y_q == YW'(IMG_H - 2));
    assign issue_addr = AW_F'(raddr_alu);

    // The delay line only moves while a frame is in flight and memory is available.
    assign pipe_hold = stall || !((state_q == StRun) || (state_q == StDrain));

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            x_q           <= XW'(1);
            y_q           <= YW'(1);
            row_base_q    <= AW_P'(IMG_W);
            issue_valid_q <= 1'b0;
            raddr_alu     <= '0;
            kernel_sel_q  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                // start is taken regardless of stall so a one-cycle pulse is never lost.
                StIdle: begin
                    if (start) begin
                        state_q      <= StRun;
                        kernel_sel_q <= kernel_sel;
                        x_q          <= XW'(1);
                        y_q          <= YW'(1);
                        row_base_q   <= AW_P'(IMG_W);
                        busy         <= 1'b1;
                    end
                end
                StRun: begin
                    if (!stall) begin
                        issue_valid_q <= 1'b1;
                        raddr_alu     <= row_base_q + AW_P'(x_q);
                        if (last_pixel) begin
                            state_q <= StDrain;
                        end
                        if (row_end) begin
                            x_q        <= XW'(1);
                            y_q        <= y_q + YW'(1);
                            row_base_q <= row_base_q + AW_P'(IMG_W);
                        end else begin
                            x_q <= x_q + XW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (!stall) begin
                        issue_valid_q <= 1'b0;
                        // Only the output stage is left, and it is written this cycle.
                        if (!issue_valid_q && !pipe_pending) begin
                            state_q   <= StDone;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    alu_pipe_delay #(
        .Depth (PIPE_LAT),
        .AddrW (AW_F)
    ) u_pipe_delay (
        .clk_i     (CLK100MHZ),
        .rst_ni    (rst_n),
        .hold_i    (pipe_hold),
        .valid_i   (issue_valid_q),
        .addr_i    (issue_addr),
        .valid_o   (pipe_valid),
        .addr_o    (pipe_addr),
        .pending_o (pipe_pending)
    );

    assign wen_alu   = pipe_valid & ~stall;
    assign waddr_alu = pipe_addr;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Scoreboard bench for alu_frame_sequencer: a driver issues frames with random stalls and
// kernel selects, a negedge monitor checks reads, writes, status and timing against a model.
module tb_alu_frame_sequencer;

    localparam int W = 4;
    localparam int H = 4;
    localparam int L = 2;
    localparam int N = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic [1:0]  kernel_sel;
    logic [1:0]  kernel_sel_q;
    logic [16:0] raddr_alu;
    logic [16:0] waddr_alu;
    logic        wen_alu;
    logic        busy;
    logic        done;
    logic [7:0]  frame_cnt;

    typedef struct {
        int start_cyc;
        int ksel;
    } frame_t;

    frame_t fr_q[$];
    int     rd_q[$];
    int     wr_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int frames = 0;

    // Monitor-side model state.
    bit cur_started = 1'b0;
    int exp_ksel = 0;
    int exp_cnt = 0;
    int stall_cnt = 0;
    int first_rd = -1;
    int first_wr = -1;
    int prev_raddr = 0;

    alu_frame_sequencer #(
        .IMG_W    (W),
        .IMG_H    (H),
        .AW_P     (17),
        .AW_F     (17),
        .PIPE_LAT (L),
        .KSEL_W   (2)
    ) dut (
        .CLK100MHZ    (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .kernel_sel   (kernel_sel),
        .kernel_sel_q (kernel_sel_q),
        .raddr_alu    (raddr_alu),
        .waddr_alu    (waddr_alu),
        .wen_alu      (wen_alu),
        .busy         (busy),
        .done         (done),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " raddr_alu"}, int'(raddr_alu), 0);
        check({tag, " waddr_alu"}, int'(waddr_alu), 0);
        check({tag, " wen_alu"}, int'(wen_alu), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " frame_cnt"}, int'(frame_cnt), 0);
        check({tag, " kernel_sel_q"}, int'(kernel_sel_q), 0);
    endtask

    // mode 0: ksel change + ignored start mid-frame, 1: 3-cycle stall after 2nd issue,
    // 2: random stalls/ksel/starts, other: quiet. abort_at >= 0 resets mid-frame.
    task automatic run_frame(input int ks, input int mode, input int abort_at);
        bit got_done = 1'b0;
        bit aborted  = 1'b0;
        @(posedge clk); #1;
        start      = 1'b1;
        stall      = 1'b0;
        kernel_sel = 2'(ks);
        for (int y = 1; y <= H - 2; y++) begin
            for (int x = 1; x <= W - 2; x++) begin
                rd_q.push_back(y * W + x);
                wr_q.push_back(y * W + x);
            end
        end
        fr_q.push_back('{start_cyc: cyc, ksel: ks});
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (mode)
                0: if (i == 2) begin
                    start      = 1'b1;
                    kernel_sel = 2'd1;
                end
                1: stall = (i >= 2 && i < 5);
                2: begin
                    stall      = ($urandom_range(3) == 0);
                    kernel_sel = 2'($urandom_range(3));
                    start      = ($urandom_range(7) == 0);
                end
                default: ;
            endcase
            if (abort_at >= 0 && i == abort_at) begin
                start = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_zero_outputs("async reset");
                @(negedge clk);
                @(posedge clk);
                #3 rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        if (!aborted) check("done within budget", int'(got_done), 1);
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            fr_q.delete();
            rd_q.delete();
            wr_q.delete();
            cur_started = 1'b0;
            exp_ksel    = 0;
            exp_cnt     = 0;
            prev_raddr  = 0;
        end else begin
            if (fr_q.size() > 0 && !cur_started && cyc > fr_q[0].start_cyc) begin
                cur_started = 1'b1;
                exp_ksel    = fr_q[0].ksel;
                stall_cnt   = 0;
                first_rd    = -1;
                first_wr    = -1;
            end
            check("kernel_sel_q", int'(kernel_sel_q), exp_ksel);
            if (int'(raddr_alu) != prev_raddr) begin
                prev_raddr = int'(raddr_alu);
                if (first_rd < 0) first_rd = cyc;
                if (rd_q.size() == 0) check("unexpected raddr", int'(raddr_alu), -1);
                else check("raddr_alu", int'(raddr_alu), rd_q.pop_front());
            end
            if (stall) check("wen_alu during stall", int'(wen_alu), 0);
            if (wen_alu) begin
                if (first_wr < 0) begin
                    first_wr = cyc;
                    if (stall_cnt == 0) check("first write latency", first_wr - first_rd, L);
                end
                if (wr_q.size() == 0) check("unexpected write", int'(waddr_alu), -1);
                else check("waddr_alu", int'(waddr_alu), wr_q.pop_front());
            end
            if (done) begin
                if (!cur_started) begin
                    check("unexpected done", int'(done), 0);
                end else begin
                    check("frame cycles", cyc - fr_q[0].start_cyc, N + L + 2 + stall_cnt);
                    check("reads left at done", rd_q.size(), 0);
                    check("writes left at done", wr_q.size(), 0);
                    void'(fr_q.pop_front());
                    cur_started = 1'b0;
                    exp_cnt     = (exp_cnt + 1) % 256;
                end
            end else if (cur_started && stall) begin
                stall_cnt++;
            end
            check("busy", int'(busy), int'(cur_started));
            check("frame_cnt", int'(frame_cnt), exp_cnt);
        end
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        kernel_sel = 2'd0;
        #12 check_zero_outputs("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        run_frame(2, 0, -1);
        run_frame(1, 1, -1);
        run_frame(3, 2, 3);

        run_frame(0, 3, -1);
        frames = 1;
        repeat (258) begin
            run_frame(int'($urandom_range(3)), 2, -1);
            frames++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("frames pending at end", fr_q.size(), 0);
        check("reads pending at end", rd_q.size(), 0);
        check("writes pending at end", wr_q.size(), 0);
        check("frame_cnt wrapped", int'(frame_cnt), frames % 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
